// File: rtl/mem_port_arbiter_if.sv
// Request/ack bundle shared by the CPU port, the debug/loader port and the RAM.
// The arbiter takes the slave side; the environment drives the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
    input  mem_dout,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output mem_addr, mem_write, mem_din
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output dbg_req, dbg_write, dbg_addr, dbg_wdata,
    output mem_dout,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input  mem_addr, mem_write, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CPU
// and the debug/loader port, with a fixed IDLE/ISSUE/DONE access sequence.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] cpu_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              lastOwner_q, lastOwner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic              grantDbg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastOwner_q <= 1'b1;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      stallCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    lastOwner_d   = lastOwner_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    grantDbg      = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.dbg_ack   = 1'b0;
    bus.dbg_rdata = '0;
    bus.mem_addr  = '0;
    bus.mem_write = 1'b0;
    bus.mem_din   = '0;
    busy          = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins (owner 1 = debug).
        if (bus.cpu_req || bus.dbg_req) begin
          grantDbg = bus.dbg_req && (!bus.cpu_req || !lastOwner_q);
          owner_d  = grantDbg;
          addr_d   = grantDbg ? bus.dbg_addr  : bus.cpu_addr;
          write_d  = grantDbg ? bus.dbg_write : bus.cpu_write;
          wdata_d  = grantDbg ? bus.dbg_wdata : bus.cpu_wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_addr  = addr_q;
        bus.mem_din   = wdata_q;
        bus.mem_write = write_q;
        state_d       = DONE;
      end
      DONE: begin
        bus.mem_addr = addr_q;
        bus.mem_din  = wdata_q;
        if (owner_q) begin
          bus.dbg_ack   = 1'b1;
          bus.dbg_rdata = bus.mem_dout;
        end else begin
          bus.cpu_ack   = 1'b1;
          bus.cpu_rdata = bus.mem_dout;
        end
        lastOwner_d = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An access aborted by reset must never ack or keep writing.
    if (reset) begin
      bus.cpu_ack   = 1'b0;
      bus.cpu_rdata = '0;
      bus.dbg_ack   = 1'b0;
      bus.dbg_rdata = '0;
      bus.mem_addr  = '0;
      bus.mem_write = 1'b0;
      bus.mem_din   = '0;
      busy          = 1'b0;
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (bus.cpu_req && !bus.cpu_ack && (stallCnt_q != {CNT_W{1'b1}}))
      stallCnt_d = stallCnt_q + CNT_W'(1);
  end

  assign cpu_stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and random accesses
// against a slot-level model of grants, ack timing, RAM contents and stalls.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              rst2;
  logic              ramInit;
  logic              busy, busy2;
  logic [CNT_W-1:0]  cpu_stall_cnt;
  logic [SAT_W-1:0]  stall2;

  int compareCount = 0;
  int failCount    = 0;
  logic [DATA_W-1:0] refMem [256];
  logic [DATA_W-1:0] ram    [256];
  bit  lastDbg;
  int  stallModel;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .cpu_stall_cnt(cpu_stall_cnt)
  );

  // Narrow counter copy so saturation is reached in a handful of cycles.
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2), .busy(busy2), .cpu_stall_cnt(stall2)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] initWord(input int i);
    if (i == 25) return 16'hFFE9;
    return 16'(i * 37) ^ 16'h5A5A;
  endfunction

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 256; i++) ram[i] <= initWord(i);
    end else begin
      if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int satStall(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cpu_ack", bus.cpu_ack, 0);
    checkOutput("rst_dbg_ack", bus.dbg_ack, 0);
    checkOutput("rst_mem_write", bus.mem_write, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_din", bus.mem_din, 0);
    checkOutput("rst_stall", cpu_stall_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    lastDbg = 1'b1;
    stallModel = 0;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_stall", cpu_stall_cnt, 0);
  endtask

  // One arbitration round: each enabled port issues a single access at the same edge.
  task automatic applyStimulus(input bit doCpu, input bit cw, input logic [7:0] ca, input logic [15:0] cd,
                               input bit doDbg, input bit dw, input logic [7:0] da, input logic [15:0] dd,
                               input bit scramble);
    bit cpuFirst;
    int cpuK, dbgK, lastK;
    bit firstW, secondW;
    logic [7:0] firstA, secondA;
    logic [15:0] firstD, secondD;
    bit expWrite;
    if (!doCpu && !doDbg) return;
    cpuFirst = doCpu && (!doDbg || lastDbg);
    cpuK  = !doCpu ? -1 : (cpuFirst ? 2 : 5);
    dbgK  = !doDbg ? -1 : (cpuFirst ? 5 : 2);
    lastK = (doCpu && doDbg) ? 5 : 2;
    firstW  = cpuFirst ? cw : dw;  firstA  = cpuFirst ? ca : da;  firstD  = cpuFirst ? cd : dd;
    secondW = cpuFirst ? dw : cw;  secondA = cpuFirst ? da : ca;  secondD = cpuFirst ? dd : cd;

    @(posedge clk); #1;
    bus.cpu_req = doCpu; bus.cpu_write = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = doDbg; bus.dbg_write = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;

    for (int k = 0; k <= lastK; k++) begin
      @(negedge clk);
      checkOutput("cpu_ack", bus.cpu_ack, 32'(k == cpuK));
      checkOutput("dbg_ack", bus.dbg_ack, 32'(k == dbgK));
      checkOutput("busy", busy, 32'((k % 3) != 0));
      expWrite = ((k == 1) && firstW) || ((k == 4) && secondW);
      checkOutput("mem_write", bus.mem_write, 32'(expWrite));
      if (k % 3 == 0) checkOutput("idle_mem_addr", bus.mem_addr, 0);
      if (k == 1) checkOutput("issue_addr", bus.mem_addr, firstA);
      if (k == 4) checkOutput("issue_addr", bus.mem_addr, secondA);
      if (k == 1 && firstW)  checkOutput("issue_din", bus.mem_din, firstD);
      if (k == 4 && secondW) checkOutput("issue_din", bus.mem_din, secondD);
      if (k == cpuK && !cw)  checkOutput("cpu_rdata", bus.cpu_rdata, refMem[ca]);
      if (k != cpuK)         checkOutput("cpu_rdata_idle", bus.cpu_rdata, 0);
      if (k == dbgK && !dw)  checkOutput("dbg_rdata", bus.dbg_rdata, refMem[da]);
      if (k != dbgK)         checkOutput("dbg_rdata_idle", bus.dbg_rdata, 0);
      if (k == cpuK && cw) refMem[ca] = cd;
      if (k == dbgK && dw) refMem[da] = dd;
      @(posedge clk); #1;
      if (k == cpuK) bus.cpu_req = 1'b0;
      if (k == dbgK) bus.dbg_req = 1'b0;
      // Inputs of the granted port change after the grant; the access must not notice.
      if (k == 0 && scramble) begin
        if (cpuFirst) begin
          bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 16'($urandom); bus.cpu_write = 1'($urandom);
        end else begin
          bus.dbg_addr = 8'($urandom); bus.dbg_wdata = 16'($urandom); bus.dbg_write = 1'($urandom);
        end
      end
    end
    lastDbg = doDbg && (!doCpu || cpuFirst);
    if (doCpu) stallModel = satStall(stallModel + cpuK);
    @(negedge clk);
    checkOutput("stall_cnt", cpu_stall_cnt, stallModel);
    checkOutput("busy_after", busy, 0);
  endtask

  // Both ports request continuously for three accesses each: grants must alternate.
  task automatic runAlternation();
    logic [7:0] ca, da;
    bit cpuFirst, ackSlot, slotCpu;
    int cpuLastK, dbgLastK;
    ca = 8'($urandom_range(0, 254));
    da = 8'($urandom_range(0, 254));
    cpuFirst = lastDbg;
    cpuLastK = cpuFirst ? 14 : 17;
    dbgLastK = cpuFirst ? 17 : 14;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = ca;
    bus.dbg_req = 1'b1; bus.dbg_write = 1'b0; bus.dbg_addr = da;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      ackSlot = (k % 3) == 2;
      slotCpu = (((k / 3) % 2) == 0) == cpuFirst;
      checkOutput("alt_cpu_ack", bus.cpu_ack, 32'(ackSlot && slotCpu));
      checkOutput("alt_dbg_ack", bus.dbg_ack, 32'(ackSlot && !slotCpu));
      if (ackSlot && slotCpu)  checkOutput("alt_cpu_rdata", bus.cpu_rdata, refMem[ca]);
      if (ackSlot && !slotCpu) checkOutput("alt_dbg_rdata", bus.dbg_rdata, refMem[da]);
      @(posedge clk); #1;
      if (k == cpuLastK) bus.cpu_req = 1'b0;
      if (k == dbgLastK) bus.dbg_req = 1'b0;
    end
    stallModel = satStall(stallModel + cpuLastK + 1 - 3);
    lastDbg = cpuFirst;
    @(negedge clk);
    checkOutput("alt_stall", cpu_stall_cnt, stallModel);
    checkOutput("alt_busy", busy, 0);
  endtask

  initial begin
    int sel;
    reset = 1'b1; rst2 = 1'b1; ramInit = 1'b1;
    bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_write = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    bus2.cpu_req = 1; bus2.cpu_write = 0; bus2.cpu_addr = 8'h01; bus2.cpu_wdata = 0;
    bus2.dbg_req = 1; bus2.dbg_write = 0; bus2.dbg_addr = 8'h02; bus2.dbg_wdata = 0;
    bus2.mem_dout = 0;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    lastDbg = 1'b1;
    stallModel = 0;
    repeat (2) @(posedge clk);
    #1 ramInit = 1'b0;

    $display("[TB] reset and single CPU read of mem[25]");
    doReset();
    applyStimulus(1, 0, 8'd25, 16'h0, 0, 0, 8'h0, 16'h0, 0);
    checkOutput("t1_stall_exact", cpu_stall_cnt, 2);

    $display("[TB] debug write then read back");
    applyStimulus(0, 0, 8'h0, 16'h0, 1, 1, 8'h10, 16'h1234, 0);
    applyStimulus(0, 0, 8'h0, 16'h0, 1, 0, 8'h10, 16'h0, 0);

    $display("[TB] simultaneous requests after reset");
    doReset();
    applyStimulus(1, 0, 8'h20, 16'h0, 1, 0, 8'h21, 16'h0, 0);

    $display("[TB] continuous requests alternate");
    runAlternation();

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(1, 3);
      applyStimulus(sel[0], 1'($urandom), 8'($urandom_range(0, 254)), 16'($urandom),
                    sel[1], 1'($urandom), 8'($urandom_range(0, 254)), 16'($urandom),
                    1'($urandom));
    end
    runAlternation();

    $display("[TB] reset during an in-flight CPU write");
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 8'hFF; bus.cpu_wdata = 16'hBEEF;
    @(negedge clk);
    checkOutput("abort_idle_ack", bus.cpu_ack, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_rst_ack", bus.cpu_ack, 0);
    checkOutput("abort_rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    lastDbg = 1'b1;
    stallModel = 0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mem_write", bus.mem_write, 0);
    checkOutput("abort_stall", cpu_stall_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort_no_ack", bus.cpu_ack, 0);
    end
    applyStimulus(1, 0, 8'h42, 16'h0, 1, 1, 8'h43, 16'h5555, 0);

    $display("[TB] stall counter saturation");
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      checkOutput("sat_cpu_ack", bus2.cpu_ack, 32'((k % 6) == 2));
      checkOutput("sat_stall", stall2, ((k - (k + 3) / 6) > 7) ? 7 : (k - (k + 3) / 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
